// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: opcodes, FSM state codes and width defaults.
package alu_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int OP_WIDTH_DEF    = 5;
  localparam int DIV_TIMEOUT_DEF = 64;

  localparam int OP_OR         = 0;
  localparam int OP_AND        = 1;
  localparam int OP_ADD        = 2;
  localparam int OP_SUB        = 3;
  localparam int OP_ADDU       = 4;
  localparam int OP_MUL        = 5;
  localparam int OP_DIV        = 6;
  localparam int OP_LAST_LEGAL = 6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_EXEC     = 2'd1;
  localparam state_t ST_DIV_WAIT = 2'd2;
  localparam state_t ST_RESP     = 2'd3;

  // Single-cycle ops are everything below the divider opcode.
  function automatic logic op_is_single(input int op);
    return (op >= OP_OR) && (op <= OP_MUL) && (OP_AND > OP_OR) && (OP_ADD > OP_AND)
           && (OP_SUB > OP_ADD) && (OP_ADDU > OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signal bundle for alu_arbiter; slave is the arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
);

  logic                    req0_valid;
  logic                    req0_ready;
  logic [DATA_WIDTH-1:0]   req0_a;
  logic [DATA_WIDTH-1:0]   req0_b;
  logic [OP_WIDTH-1:0]     req0_op;

  logic                    req1_valid;
  logic                    req1_ready;
  logic [DATA_WIDTH-1:0]   req1_a;
  logic [DATA_WIDTH-1:0]   req1_b;
  logic [OP_WIDTH-1:0]     req1_op;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [2*DATA_WIDTH-1:0] rsp_result;
  logic                    rsp_err;

  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [OP_WIDTH-1:0]     alu_op;
  logic [2*DATA_WIDTH-1:0] comb_result;

  logic                    div_start;
  logic                    div_done;
  logic [2*DATA_WIDTH-1:0] div_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready,
    output alu_a, alu_b, alu_op,
    input  comb_result,
    output div_start,
    input  div_done, div_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready,
    input  alu_a, alu_b, alu_op,
    output comb_result,
    input  div_start,
    output div_done, div_result
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that was not granted last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU: arbitrates two requesters, sequences single-cycle
// ops and the divider handshake, returns tagged results. Optional macro: ALU_ARB_DIV_TIMEOUT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int OP_WIDTH    = OP_WIDTH_DEF,
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam logic [OP_WIDTH-1:0] OP_DIV_W        = OP_WIDTH'(OP_DIV);
  localparam logic [OP_WIDTH-1:0] OP_LAST_LEGAL_W = OP_WIDTH'(OP_LAST_LEGAL);

  state_t                  state;
  logic                    last_grant;
  logic                    grant_valid;
  logic                    grant_id;
  logic                    accept;

  logic [DATA_WIDTH-1:0]   alu_a_q;
  logic [DATA_WIDTH-1:0]   alu_b_q;
  logic [OP_WIDTH-1:0]     alu_op_q;
  logic                    rsp_id_q;
  logic [2*DATA_WIDTH-1:0] rsp_result_q;
  logic                    rsp_err_q;

  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [OP_WIDTH-1:0]     sel_op;

`ifdef ALU_ARB_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
  logic [CNT_W-1:0] div_cnt;
`endif

  rr_arb2 u_rr_arb2 (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Ready is combinational and gated by reset so nothing is accepted while it is held.
  assign accept         = (state == ST_IDLE) && !reset && grant_valid;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
  assign sel_op = grant_id ? bus.req1_op : bus.req0_op;

  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.div_start  = (state == ST_EXEC) && (alu_op_q == OP_DIV_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_DIV_TIMEOUT_EN
      div_cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a_q    <= sel_a;
            alu_b_q    <= sel_b;
            alu_op_q   <= sel_op;
            rsp_id_q   <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (alu_op_q > OP_LAST_LEGAL_W) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            state        <= ST_RESP;
          end else if (alu_op_q == OP_DIV_W) begin
`ifdef ALU_ARB_DIV_TIMEOUT_EN
            div_cnt      <= '0;
`endif
            state        <= ST_DIV_WAIT;
          end else begin
            rsp_result_q <= bus.comb_result;
            rsp_err_q    <= 1'b0;
            state        <= ST_RESP;
          end
        end
        // A done in the same cycle the timeout expires takes priority.
        ST_DIV_WAIT: begin
          if (bus.div_done) begin
            rsp_result_q <= bus.div_result;
            rsp_err_q    <= 1'b0;
            state        <= ST_RESP;
`ifdef ALU_ARB_DIV_TIMEOUT_EN
          end else if (div_cnt == CNT_LAST) begin
            rsp_result_q <= '1;
            rsp_err_q    <= 1'b1;
            state        <= ST_RESP;
          end else begin
            div_cnt      <= div_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
